// File: rtl/gmii_pkt_gen_pkg.sv
// ----------------------------------------------------------------------------
// gmii_pkt_gen_pkg
//   Shared constants, state encoding and helper functions for the GMII test
//   traffic generator and its byte-wide CRC-32 engine. The receive-side
//   checker imports the same package so both ends agree on framing.
// ----------------------------------------------------------------------------
package gmii_pkt_gen_pkg;

    // Line-level byte constants
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // Frame limits (bytes, DA through FCS inclusive)
    localparam int unsigned MIN_FRAME    = 64;
    localparam int unsigned MAX_FRAME    = 1518;
    localparam int unsigned HDR_LEN      = 14;
    localparam int unsigned FCS_LEN      = 4;
    localparam int unsigned PREAMBLE_LEN = 7;
    localparam int unsigned SEQ_LEN      = 4;

    // CRC-32 (IEEE 802.3), reflected form
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_HDR      = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } state_e;

    // One byte of reflected CRC-32, data consumed LSB first
    function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                  input logic [7:0]  d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
        end
        return c;
    endfunction

    // Frame length clamp into the legal Ethernet range
    function automatic logic [15:0] clamp_frame_len(input logic [15:0] len);
        logic [15:0] r;
        r = len;
        if (len < 16'(MIN_FRAME)) begin
            r = 16'(MIN_FRAME);
        end else if (len > 16'(MAX_FRAME)) begin
            r = 16'(MAX_FRAME);
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_crc32_d8.sv
// ----------------------------------------------------------------------------
// gmii_crc32_d8
//   Byte-wide running CRC-32 register (IEEE 802.3, reflected, init all-ones).
//   The value is not inverted; the user complements it when emitting FCS.
//
//   clk     in   clock
//   resetn  in   asynchronous active-low reset (crc -> all-ones)
//   init    in   reload all-ones (has priority over en)
//   en      in   fold d into the CRC this cycle
//   d       in   data byte
//   crc     out  registered running CRC
// ----------------------------------------------------------------------------
module gmii_crc32_d8
    import gmii_pkt_gen_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_d8_next(crc, d);
        end
    end

endmodule

// File: rtl/gmii_pkt_gen.sv
// ----------------------------------------------------------------------------
// gmii_pkt_gen
//   GMII test-traffic source (gtx_clk domain). Sends bursts of Ethernet
//   frames: preamble, SFD, DA/SA/EtherType, payload starting with a 32-bit
//   big-endian sequence number followed by an incrementing byte pattern,
//   FCS, then an inter-frame gap. A burst is N frames or, with
//   frame_count == 0, continuous until stop.
//
//   gtx_clk      in   125 MHz transmit clock
//   gtx_resetn   in   asynchronous active-low reset
//   start        in   pulse, begins a burst (IDLE only, stop low)
//   stop         in   pulse, ends the burst after the current frame + gap
//   frame_len    in   DA..FCS bytes, clamped to 64..1518
//   frame_count  in   frames per burst, 0 = continuous
//   ifg          in   gap bytes, clamped up to C_MIN_IFG
//   dst_mac      in   destination MAC, MSB byte first
//   src_mac      in   source MAC, MSB byte first
//   gmii_txd     out  registered GMII data
//   gmii_tx_en   out  registered GMII enable
//   gmii_tx_er   out  GMII error, constant 0
//   busy         out  high from the cycle after start until IDLE re-entered
//   frames_sent  out  frames completed since the last start
// ----------------------------------------------------------------------------
module gmii_pkt_gen
    import gmii_pkt_gen_pkg::*;
#(
    parameter logic [15:0] C_ETHERTYPE = 16'h88B5,
    parameter int unsigned C_MIN_IFG   = 12
) (
    input  logic        gtx_clk,
    input  logic        gtx_resetn,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] frame_len,
    input  logic [31:0] frame_count,
    input  logic [7:0]  ifg,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [31:0] frames_sent
);

    localparam int unsigned PAYLOAD_OVH = HDR_LEN + FCS_LEN;

    state_e       state_q;
    logic [15:0]  cnt_q;
    logic [15:0]  len_q;
    logic [31:0]  count_q;
    logic [7:0]   ifg_q;
    logic [47:0]  dst_q;
    logic [47:0]  src_q;
    logic [31:0]  seq_q;
    logic [31:0]  frames_q;
    logic         stop_pend_q;
    logic [7:0]   txd_q;
    logic         tx_en_q;
    logic         busy_q;

    logic [7:0]   byte_c;
    logic         phase_last_c;
    logic         crc_en_c;
    logic         crc_init_c;
    logic         done_c;
    logic [3:0]   hdr_sel_c;
    logic [1:0]   seq_sel_c;
    logic [111:0] hdr_c;
    logic [31:0]  crc_c;
    logic [7:0]   ifg_clamped_c;

    assign hdr_c         = {dst_q, src_q, C_ETHERTYPE};
    assign ifg_clamped_c = (ifg < 8'(C_MIN_IFG)) ? 8'(C_MIN_IFG) : ifg;

    // CRC restarts during preamble and accumulates exactly DA..payload
    assign crc_init_c = (state_q == ST_PREAMBLE);

    // Burst end is only acted on at the last gap cycle
    assign done_c = ((count_q != 32'd0) && (frames_q == count_q)) || stop_pend_q || stop;

    gmii_crc32_d8 u_crc (
        .clk    (gtx_clk),
        .resetn (gtx_resetn),
        .init   (crc_init_c),
        .en     (crc_en_c),
        .d      (byte_c),
        .crc    (crc_c)
    );

    // Byte to drive for the current state/counter, plus end-of-phase flag
    always_comb begin
        byte_c       = 8'h00;
        phase_last_c = 1'b0;
        crc_en_c     = 1'b0;
        hdr_sel_c    = 4'(HDR_LEN - 1) - cnt_q[3:0];
        seq_sel_c    = 2'd3 - cnt_q[1:0];
        case (state_q)
            ST_PREAMBLE: begin
                byte_c       = PREAMBLE_BYTE;
                phase_last_c = (cnt_q == 16'(PREAMBLE_LEN - 1));
            end
            ST_SFD: begin
                byte_c       = SFD_BYTE;
                phase_last_c = 1'b1;
            end
            ST_HDR: begin
                byte_c       = 8'(hdr_c >> {hdr_sel_c, 3'b000});
                crc_en_c     = 1'b1;
                phase_last_c = (cnt_q == 16'(HDR_LEN - 1));
            end
            ST_PAYLOAD: begin
                // Sequence number big-endian, then pattern from 0x00 (wraps by truncation)
                if (cnt_q < 16'(SEQ_LEN)) begin
                    byte_c = 8'(seq_q >> {seq_sel_c, 3'b000});
                end else begin
                    byte_c = 8'(cnt_q - 16'(SEQ_LEN));
                end
                crc_en_c     = 1'b1;
                phase_last_c = (cnt_q == len_q - 16'(PAYLOAD_OVH + 1));
            end
            ST_FCS: begin
                // Complemented CRC, least significant byte first
                byte_c       = ~8'(crc_c >> {cnt_q[1:0], 3'b000});
                phase_last_c = (cnt_q == 16'(FCS_LEN - 1));
            end
            ST_IFG: begin
                byte_c       = 8'h00;
                phase_last_c = (cnt_q == {8'd0, ifg_q} - 16'd1);
            end
            default: begin
                byte_c       = 8'h00;
                phase_last_c = 1'b0;
            end
        endcase
    end

    // Transmit FSM; outputs are registered from the current state's byte
    always_ff @(posedge gtx_clk or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            len_q       <= 16'(MIN_FRAME);
            count_q     <= 32'd0;
            ifg_q       <= 8'(C_MIN_IFG);
            dst_q       <= 48'd0;
            src_q       <= 48'd0;
            seq_q       <= 32'd0;
            frames_q    <= 32'd0;
            stop_pend_q <= 1'b0;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_q   <= 8'h00;
                    tx_en_q <= 1'b0;
                    if (start && !stop) begin
                        len_q       <= clamp_frame_len(frame_len);
                        count_q     <= frame_count;
                        ifg_q       <= ifg_clamped_c;
                        dst_q       <= dst_mac;
                        src_q       <= src_mac;
                        seq_q       <= 32'd0;
                        frames_q    <= 32'd0;
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= 16'd0;
                        state_q     <= ST_PREAMBLE;
                    end
                end
                default: begin
                    txd_q   <= byte_c;
                    tx_en_q <= (state_q != ST_IFG);
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    cnt_q <= phase_last_c ? 16'd0 : cnt_q + 16'd1;
                    if (phase_last_c) begin
                        case (state_q)
                            ST_PREAMBLE: state_q <= ST_SFD;
                            ST_SFD:      state_q <= ST_HDR;
                            ST_HDR:      state_q <= ST_PAYLOAD;
                            ST_PAYLOAD:  state_q <= ST_FCS;
                            ST_FCS: begin
                                frames_q <= frames_q + 32'd1;
                                seq_q    <= seq_q + 32'd1;
                                state_q  <= ST_IFG;
                            end
                            ST_IFG: begin
                                if (done_c) begin
                                    busy_q      <= 1'b0;
                                    stop_pend_q <= 1'b0;
                                    state_q     <= ST_IDLE;
                                end else begin
                                    state_q     <= ST_PREAMBLE;
                                end
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign gmii_txd    = txd_q;
    assign gmii_tx_en  = tx_en_q;
    assign gmii_tx_er  = 1'b0;
    assign busy        = busy_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_gmii_pkt_gen.sv
// ----------------------------------------------------------------------------
// tb_gmii_pkt_gen
//   Scoreboard bench: each start pushes the expected wire bytes, enable-run
//   lengths and gap lengths; a negedge monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_gmii_pkt_gen;

    localparam logic [47:0] DST = 48'h0A1B_2C3D_4E5F;
    localparam logic [47:0] SRC = 48'h0211_2233_4455;

    logic        gtx_clk    = 1'b0;
    logic        gtx_resetn = 1'b0;
    logic        start      = 1'b0;
    logic        stop       = 1'b0;
    logic [15:0] frame_len  = 16'd64;
    logic [31:0] frame_count = 32'd1;
    logic [7:0]  ifg        = 8'd12;
    logic [47:0] dst_mac    = DST;
    logic [47:0] src_mac    = SRC;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [31:0] frames_sent;

    gmii_pkt_gen dut (
        .gtx_clk     (gtx_clk),
        .gtx_resetn  (gtx_resetn),
        .start       (start),
        .stop        (stop),
        .frame_len   (frame_len),
        .frame_count (frame_count),
        .ifg         (ifg),
        .dst_mac     (dst_mac),
        .src_mac     (src_mac),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #4 gtx_clk = ~gtx_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_bytes[$];
    int          exp_lens[$];
    int          exp_gaps[$];
    logic [31:0] crc_tbl[256];

    bit mon_en     = 1'b0;
    bit in_frame   = 1'b0;
    bit in_gap     = 1'b0;
    int gap_cnt    = 0;
    int mon_run    = 0;
    int mon_frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got=%0h (t=%0t)", name, act, $time);
    endtask

    // Expected wire image of one frame; len is the already-clamped length
    task automatic push_frame(input int len, input logic [31:0] seq, input int gap);
        logic [7:0]  data[$];
        logic [31:0] c;
        logic [47:0] d;
        logic [47:0] s;
        d = DST;
        s = SRC;
        for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        for (int i = 0; i < 6; i++) data.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) data.push_back(s[47-8*i -: 8]);
        data.push_back(8'h88);
        data.push_back(8'hB5);
        for (int i = 0; i < 4; i++) data.push_back(seq[31-8*i -: 8]);
        for (int i = 0; i < len - 22; i++) data.push_back(8'(i));
        c = 32'hFFFF_FFFF;
        foreach (data[i]) begin
            c = crc_tbl[c[7:0] ^ data[i]] ^ (c >> 8);
            exp_bytes.push_back(data[i]);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_bytes.push_back(c[8*i +: 8]);
        exp_lens.push_back(len + 8);
        exp_gaps.push_back(gap);
    endtask

    // Monitor: compares every enabled byte, run length and gap length
    always @(negedge gtx_clk) begin
        if (mon_en) begin
            if (gmii_tx_en) begin
                if (in_gap) begin
                    if (exp_gaps.size() == 0) note_fail("gap_unexpected", 32'(gap_cnt));
                    else chk("gap_len", 32'(gap_cnt), 32'(exp_gaps.pop_front()));
                    in_gap = 1'b0;
                end
                in_frame = 1'b1;
                if (exp_bytes.size() == 0) note_fail("byte_unexpected", 32'(gmii_txd));
                else chk($sformatf("txd f%0d b%0d", mon_frames, mon_run),
                         32'(gmii_txd), 32'(exp_bytes.pop_front()));
                mon_run++;
            end else begin
                if (in_frame) begin
                    if (exp_lens.size() == 0) note_fail("len_unexpected", 32'(mon_run));
                    else chk("tx_en_run", 32'(mon_run), 32'(exp_lens.pop_front()));
                    chk("tx_er", 32'(gmii_tx_er), 32'd0);
                    mon_frames++;
                    mon_run  = 0;
                    in_frame = 1'b0;
                    in_gap   = 1'b1;
                    gap_cnt  = 0;
                end
                if (in_gap) begin
                    chk("gap_txd", 32'(gmii_txd), 32'd0);
                    gap_cnt++;
                    if (!busy) begin
                        if (exp_gaps.size() == 0) note_fail("gap_unexpected", 32'(gap_cnt));
                        else chk("final_gap", 32'(gap_cnt), 32'(exp_gaps.pop_front()));
                        in_gap = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] len, input logic [31:0] cnt, input logic [7:0] g);
        @(negedge gtx_clk);
        #1;
        frame_len   = len;
        frame_count = cnt;
        ifg         = g;
        start       = 1'b1;
        @(negedge gtx_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy) begin
            @(negedge gtx_clk);
            k++;
            if (k > budget) begin
                note_fail("wait_idle_timeout", 32'(k));
                break;
            end
        end
        repeat (2) @(negedge gtx_clk);
    endtask

    task automatic wait_pos(input int fr, input int b, input int budget);
        int k;
        k = 0;
        while (!(mon_frames == fr && mon_run >= b)) begin
            @(negedge gtx_clk);
            k++;
            if (k > budget) begin
                note_fail("wait_pos_timeout", 32'(k));
                break;
            end
        end
    endtask

    task automatic end_check(input string tag, input int exp_frames);
        chk({tag, "_frames_sent"}, frames_sent, 32'(exp_frames));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
        chk({tag, "_gaps_left"}, 32'(exp_gaps.size()), 32'd0);
    endtask

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] r;
            r = 32'(n);
            for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
            crc_tbl[n] = r;
        end

        // Reset values
        repeat (3) @(negedge gtx_clk);
        chk("rst_txd", 32'(gmii_txd), 32'd0);
        chk("rst_tx_en", 32'(gmii_tx_en), 32'd0);
        chk("rst_tx_er", 32'(gmii_tx_er), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", frames_sent, 32'd0);
        #1 gtx_resetn = 1'b1;
        mon_en = 1'b1;

        // 1: minimum frame, single, latency check
        mon_frames = 0;
        push_frame(64, 32'd0, 12);
        do_start(16'd64, 32'd1, 8'd12);
        chk("lat_busy_n1", 32'(busy), 32'd1);
        chk("lat_tx_en_n1", 32'(gmii_tx_en), 32'd0);
        @(negedge gtx_clk);
        chk("lat_tx_en_n2", 32'(gmii_tx_en), 32'd1);
        chk("lat_txd_n2", 32'(gmii_txd), 32'h55);
        wait_idle(400);
        end_check("t1", 1);

        // stop while idle must not leave anything pending
        @(negedge gtx_clk);
        #1 stop = 1'b1;
        @(negedge gtx_clk);
        #1 stop = 1'b0;
        chk("stop_idle_busy", 32'(busy), 32'd0);

        // 2: undersized frame and gap clamp
        mon_frames = 0;
        push_frame(64, 32'd0, 12);
        do_start(16'd10, 32'd1, 8'd3);
        wait_idle(400);
        end_check("t2", 1);

        // 3: three-frame burst, sequence 0..2
        mon_frames = 0;
        for (int i = 0; i < 3; i++) push_frame(100, 32'(i), 12);
        do_start(16'd100, 32'd3, 8'd12);
        wait_idle(1000);
        end_check("t3", 3);

        // 4: continuous, stop mid-payload of the fifth frame
        mon_frames = 0;
        for (int i = 0; i < 5; i++) push_frame(64, 32'(i), 12);
        do_start(16'd64, 32'd0, 8'd12);
        wait_pos(4, 40, 1000);
        #1 stop = 1'b1;
        @(negedge gtx_clk);
        #1 stop = 1'b0;
        wait_idle(400);
        end_check("t4", 5);

        // 5: reset asserted mid-header of the second frame
        mon_frames = 0;
        for (int i = 0; i < 3; i++) push_frame(64, 32'(i), 12);
        do_start(16'd64, 32'd3, 8'd12);
        wait_pos(1, 13, 600);
        chk("pre_rst_frames", frames_sent, 32'd1);
        #2;
        mon_en     = 1'b0;
        gtx_resetn = 1'b0;
        #1;
        chk("midrst_tx_en", 32'(gmii_tx_en), 32'd0);
        chk("midrst_txd", 32'(gmii_txd), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        exp_bytes.delete();
        exp_lens.delete();
        exp_gaps.delete();
        in_frame = 1'b0;
        in_gap   = 1'b0;
        mon_run  = 0;
        @(negedge gtx_clk);
        #1 gtx_resetn = 1'b1;
        repeat (3) @(negedge gtx_clk);
        chk("postrst_frames", frames_sent, 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_tx_en", 32'(gmii_tx_en), 32'd0);

        // start during a burst is ignored, config stays latched
        mon_frames = 0;
        mon_en     = 1'b1;
        for (int i = 0; i < 2; i++) push_frame(64, 32'(i), 12);
        do_start(16'd64, 32'd2, 8'd12);
        wait_pos(0, 30, 200);
        do_start(16'd100, 32'd5, 8'd30);
        wait_idle(600);
        end_check("t5", 2);

        // 6: maximum frame, pattern wrap, wider gap
        mon_frames = 0;
        push_frame(1518, 32'd0, 20);
        do_start(16'd1518, 32'd1, 8'd20);
        wait_idle(2000);
        end_check("t6", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
